// File: rtl/nios2_debug_mem_arbiter.sv
// Round-robin sharing of the OCI monitor RAM between the JTAG debug path and the CPU debug slave.
// Define DEBUG_MEM_CPU_WP_EN to block CPU writes to the upper half of the RAM.

module nios2_debug_mem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RD  = 2'd1,
    ST_JTAG_RD = 2'd2
  } state_e;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                jpend_q, jpend_d;
  logic                jop_wr_q, jop_wr_d;
  logic [DATA_W-1:0]   jdata_q, jdata_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic cpu_req;
  logic cpu_wp;
  logic grant_j;
  logic grant_c;
  logic j_clear;
  logic j_strobe;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef DEBUG_MEM_CPU_WP_EN
  assign cpu_wp = cpu_address[ADDR_W-1];
`else
  assign cpu_wp = 1'b0;
`endif

  // Round-robin: on a tie the requester not granted last wins.
  assign cpu_req  = cpu_read | cpu_write;
  assign grant_j  = (state_q == ST_IDLE) && jpend_q && (!cpu_req || (last_grant_q == GRANT_CPU));
  assign grant_c  = (state_q == ST_IDLE) && cpu_req && !grant_j;
  assign j_clear  = (grant_j && jop_wr_q) || (state_q == ST_JTAG_RD);
  assign j_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Next-state logic for the sequencer and the JTAG pending buffer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    jpend_d      = jpend_q;
    jop_wr_d     = jop_wr_q;
    jdata_d      = jdata_q;
    jaddr_d      = jaddr_q;
    rd_addr_d    = rd_addr_q;
    mon_dreg_d   = mon_dreg_q;
    ready_d      = ready_q;
    error_d      = error_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_j) begin
          last_grant_d = GRANT_JTAG;
          if (!jop_wr_q) begin
            state_d   = ST_JTAG_RD;
            rd_addr_d = jaddr_q;
          end
        end else if (grant_c) begin
          last_grant_d = GRANT_CPU;
          if (!cpu_write) begin
            state_d   = ST_CPU_RD;
            rd_addr_d = cpu_address;
          end
        end
      end
      ST_CPU_RD:  state_d = ST_IDLE;
      ST_JTAG_RD: begin
        state_d    = ST_IDLE;
        mon_dreg_d = ram_rdata;
      end
      default:    state_d = ST_IDLE;
    endcase

    if (j_clear) begin
      jpend_d = 1'b0;
      jaddr_d = jaddr_q + ADDR_W'(1);
      ready_d = 1'b1;
    end

    // A strobe landing on the cycle the buffer drains is accepted.
    if (j_strobe) begin
      if (jpend_q && !j_clear) begin
        error_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        jaddr_d = jdo[ADDR_W+16:17];
        error_d = 1'b0;
        if (jdo[35]) begin
          jpend_d  = 1'b1;
          jop_wr_d = 1'b0;
          ready_d  = 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        jpend_d  = 1'b1;
        jop_wr_d = 1'b1;
        jdata_d  = jdo[34:3];
        ready_d  = 1'b0;
      end else begin
        jpend_d  = 1'b1;
        jop_wr_d = 1'b0;
        ready_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_CPU;
      jpend_q      <= 1'b0;
      jop_wr_q     <= 1'b0;
      jdata_q      <= '0;
      jaddr_q      <= '0;
      rd_addr_q    <= '0;
      mon_dreg_q   <= '0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      jpend_q      <= jpend_d;
      jop_wr_q     <= jop_wr_d;
      jdata_q      <= jdata_d;
      jaddr_q      <= jaddr_d;
      rd_addr_q    <= rd_addr_d;
      mon_dreg_q   <= mon_dreg_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  // RAM port and Avalon handshake; reset forces the port quiet.
  always_comb begin
    ram_addr        = cpu_address;
    ram_we          = 1'b0;
    ram_be          = cpu_byteenable;
    ram_wdata       = cpu_writedata;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_j) begin
          ram_addr  = jaddr_q;
          ram_we    = jop_wr_q;
          ram_be    = BE_W'('1);
          ram_wdata = jdata_q;
        end else if (grant_c) begin
          ram_we          = cpu_write & ~cpu_wp;
          cpu_waitrequest = ~cpu_write;
        end
      end
      ST_CPU_RD: begin
        ram_addr        = rd_addr_q;
        cpu_waitrequest = 1'b0;
        cpu_readdata    = ram_rdata;
      end
      ST_JTAG_RD: ram_addr = rd_addr_q;
      default: ;
    endcase

    if (!reset_n) begin
      ram_we          = 1'b0;
      cpu_waitrequest = 1'b1;
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_debug_mem_arbiter.sv
// Bench for nios2_debug_mem_arbiter: transaction-level model (queue + reference memory) checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.

module tb_nios2_debug_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_waitrequest;
  logic [31:0]       cpu_readdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  always #5 clk = ~clk;

  nios2_debug_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit wp_hit(input logic [ADDR_W-1:0] a);
`ifdef DEBUG_MEM_CPU_WP_EN
    return a[ADDR_W-1];
`else
    return (a != a);
`endif
  endfunction

  // Synchronous-read single-port RAM with byte enables
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_we)
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model: a one-deep JTAG request queue, a shadow memory, and the data phase owed next cycle.
  typedef struct { bit wr; logic [31:0] data; } jreq_t;
  localparam int PH_NONE = 0, PH_CPU = 1, PH_JTAG = 2;

  jreq_t       jq[$];
  logic [31:0] ref_mem [DEPTH];
  int          m_jaddr;
  bit          m_last_j;
  int          m_phase;
  logic [31:0] m_rd_val;
  bit          m_ready, m_err;
  logic [31:0] m_mon;

  task automatic m_reset();
    jq.delete();
    m_jaddr = 0; m_last_j = 0; m_phase = PH_NONE; m_rd_val = '0;
    m_ready = 1; m_err = 0; m_mon = '0;
  endtask

  task automatic model_step();
    bit          cpu_req, exp_we, exp_wait, rd_grant;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    jreq_t       r;
    chk("monitor_ready", 32'(monitor_ready), 32'(m_ready));
    chk("monitor_error", 32'(monitor_error), 32'(m_err));
    chk("MonDReg", MonDReg, m_mon);
    cpu_req = cpu_read | cpu_write;
    exp_we = 0; exp_wait = 1; rd_grant = 0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0;
    if (m_phase == PH_CPU) begin
      exp_wait = 0;
      chk("cpu_readdata", cpu_readdata, m_rd_val);
      m_phase = PH_NONE;
    end else if (m_phase == PH_JTAG) begin
      m_mon = m_rd_val;
      void'(jq.pop_front());
      m_jaddr = (m_jaddr + 1) % DEPTH;
      m_ready = 1;
      m_phase = PH_NONE;
    end else if (jq.size() != 0 && (!cpu_req || !m_last_j)) begin
      r = jq[0];
      m_last_j = 1;
      exp_addr = 32'(m_jaddr);
      if (r.wr) begin
        exp_we = 1; exp_wdata = r.data; exp_be = 4'hF;
        ref_mem[m_jaddr] = r.data;
        void'(jq.pop_front());
        m_jaddr = (m_jaddr + 1) % DEPTH;
        m_ready = 1;
      end else begin
        rd_grant = 1;
        m_rd_val = ref_mem[m_jaddr];
        m_phase  = PH_JTAG;
      end
    end else if (cpu_req) begin
      m_last_j = 0;
      exp_addr = 32'(cpu_address);
      if (cpu_write) begin
        exp_wait = 0;
        if (!wp_hit(cpu_address)) begin
          exp_we = 1; exp_wdata = cpu_writedata; exp_be = cpu_byteenable;
          for (int k = 0; k < 4; k++)
            if (cpu_byteenable[k]) ref_mem[cpu_address][8*k +: 8] = cpu_writedata[8*k +: 8];
        end
      end else begin
        rd_grant = 1;
        m_rd_val = ref_mem[cpu_address];
        m_phase  = PH_CPU;
      end
    end
    chk("cpu_waitrequest", 32'(cpu_waitrequest), 32'(exp_wait));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) begin
      chk("ram_addr_wr", 32'(ram_addr), exp_addr);
      chk("ram_wdata", ram_wdata, exp_wdata);
      chk("ram_be", 32'(ram_be), 32'(exp_be));
    end
    if (rd_grant) chk("ram_addr_rd", 32'(ram_addr), exp_addr);
    if (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a) begin
      if (jq.size() != 0) m_err = 1;
      else if (take_action_ocimem_a) begin
        m_jaddr = int'(jdo[ADDR_W+16:17]);
        m_err = 0;
        if (jdo[35]) begin jq.push_back('{wr: 1'b0, data: 32'h0}); m_ready = 0; end
      end else if (take_action_ocimem_b) begin
        jq.push_back('{wr: 1'b1, data: jdo[34:3]});
        m_ready = 0;
      end else begin
        jq.push_back('{wr: 1'b0, data: 32'h0});
        m_ready = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_reset();
        chk("rst_waitrequest", 32'(cpu_waitrequest), 32'd1);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_monitor_ready", 32'(monitor_ready), 32'(m_ready));
        chk("rst_monitor_error", 32'(monitor_error), 32'(m_err));
        chk("rst_MonDReg", MonDReg, m_mon);
      end else begin
        model_step();
      end
    end
  end

  // Stimulus
  int          waits;
  bit          done, acc;
  logic [31:0] rdat;
  int          k, rst_hold;
  logic [63:0] r64;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic jtag_a(input logic [ADDR_W-1:0] a, input bit rd);
    jdo = '0; jdo[ADDR_W+16:17] = a; jdo[35] = rd;
    take_action_ocimem_a = 1; nxt(); take_action_ocimem_a = 0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_action_ocimem_b = 1; nxt(); take_action_ocimem_b = 0;
  endtask

  task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cpu_address = a; cpu_writedata = d; cpu_byteenable = 4'hF; cpu_write = 1;
    waits = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) done = 1; else waits++;
      nxt();
    end
    cpu_write = 0;
    chk("cpu_wr_done", 32'(done), 32'd1);
  endtask

  task automatic cpu_rd(input logic [ADDR_W-1:0] a);
    cpu_address = a; cpu_read = 1;
    waits = 0; done = 0; rdat = '0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin done = 1; rdat = cpu_readdata; end else waits++;
      nxt();
    end
    cpu_read = 0;
    chk("cpu_rd_done", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; jdo = '0;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    repeat (3) nxt();
    reset_n = 1;
    nxt();

    // JTAG write of 0xDEADBEEF to 0x10
    jtag_a(8'h10, 0);
    jtag_b(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready_low", 32'(monitor_ready), 32'd0);
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'h10);
    nxt();
    @(negedge clk);
    chk("t1_ready_high", 32'(monitor_ready), 32'd1);
    nxt();
    chk("t1_model_jaddr", 32'(m_jaddr), 32'h11);

    // JTAG read back from 0x10
    jtag_a(8'h10, 1);
    @(negedge clk);
    chk("t2_ready_low", 32'(monitor_ready), 32'd0);
    nxt(); nxt();
    @(negedge clk);
    chk("t2_MonDReg", MonDReg, 32'hDEADBEEF);
    chk("t2_ready_high", 32'(monitor_ready), 32'd1);
    nxt();
    chk("t2_model_jaddr", 32'(m_jaddr), 32'h11);

    // Contention after reset: JTAG wins first tie, CPU the next
    reset_n = 0; nxt(); nxt(); reset_n = 1; nxt();
    cpu_wr(8'h05, 32'hCAFE0005);
    chk("t3_wr_waits", 32'(waits), 32'd0);
    jtag_a(8'h10, 1);
    cpu_address = 8'h05; cpu_read = 1; waits = 0; done = 0; rdat = '0;
    for (int i = 0; i < 10 && !done; i++) begin
      take_no_action_ocimem_a = (i == 1);
      @(negedge clk);
      if (!cpu_waitrequest) begin done = 1; rdat = cpu_readdata; end else waits++;
      nxt();
    end
    take_no_action_ocimem_a = 0; cpu_read = 0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_waits", 32'(waits), 32'd3);
    chk("t3_readdata", rdat, 32'hCAFE0005);
    repeat (4) nxt();
    @(negedge clk);
    chk("t3_no_error", 32'(monitor_error), 32'd0);
    nxt();

    // Overrun under continuous CPU reads
    cpu_address = 8'h33; cpu_read = 1;
    jtag_a(8'h20, 0);
    take_no_action_ocimem_a = 1; nxt(); nxt(); take_no_action_ocimem_a = 0;
    @(negedge clk);
    chk("t4_error_set", 32'(monitor_error), 32'd1);
    repeat (8) nxt();
    chk("t4_model_jaddr", 32'(m_jaddr), 32'h21);
    cpu_read = 0;
    nxt();
    jtag_a(8'h30, 0);
    @(negedge clk);
    chk("t4_error_clear", 32'(monitor_error), 32'd0);
    nxt();

    // Address wrap
    jtag_a(8'hFF, 0);
    jtag_b(32'h0BADF00D);
    nxt(); nxt();
    jtag_b(32'h11112222);
    nxt(); nxt();
    chk("t5_model_jaddr", 32'(m_jaddr), 32'h01);
    cpu_rd(8'hFF);
    chk("t5_rd_ff", rdat, 32'h0BADF00D);
    chk("t5_rd_waits", 32'(waits), 32'd1);
    cpu_rd(8'h00);
    chk("t5_rd_00", rdat, 32'h11112222);

    // CPU write protection of the upper half
    jtag_a(8'h80, 0);
    jtag_b(32'hA5A5A5A5);
    nxt(); nxt(); nxt();
    cpu_wr(8'h80, 32'h12345678);
    chk("t6_wr80_waits", 32'(waits), 32'd0);
    cpu_wr(8'h7F, 32'h12345678);
    chk("t6_wr7f_waits", 32'(waits), 32'd0);
    cpu_rd(8'h80);
`ifdef DEBUG_MEM_CPU_WP_EN
    chk("t6_rd80", rdat, 32'hA5A5A5A5);
`else
    chk("t6_rd80", rdat, 32'h12345678);
`endif
    cpu_rd(8'h7F);
    chk("t6_rd7f", rdat, 32'h12345678);

    // Randomized traffic
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = reset_n && (cpu_read | cpu_write) && !cpu_waitrequest;
      nxt();
      take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset_n = 1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset_n = 0; rst_hold = 2;
      end
      if (!(cpu_read | cpu_write) || acc) begin
        cpu_read = 0; cpu_write = 0;
        if ($urandom_range(0, 2) != 0) begin
          k = int'($urandom_range(0, 7));
          cpu_read  = (k <= 3) || (k == 7);
          cpu_write = (k >= 4);
          cpu_address    = ADDR_W'($urandom);
          cpu_writedata  = $urandom;
          cpu_byteenable = 4'($urandom);
        end
      end
      r64 = {$urandom, $urandom};
      jdo = r64[37:0];
      k = int'($urandom_range(0, 7));
      if (k == 0) take_action_ocimem_a = 1;
      else if (k == 1) take_action_ocimem_b = 1;
      else if (k == 2) take_no_action_ocimem_a = 1;
    end
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    cpu_read = 0; cpu_write = 0; reset_n = 1;
    repeat (6) nxt();

    k = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) k++;
    chk("ram_image_mismatches", 32'(k), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
